// File: rtl/demux_stream.sv
// demux_stream: steers an input stream to one of four single-register output channels,
// each with a wrapping count of words delivered downstream.
module demux_stream #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [1:0]    s,
  output logic [W-1:0]  f0,
  output logic [W-1:0]  f1,
  output logic [W-1:0]  f2,
  output logic [W-1:0]  f3,
  output logic          f0_valid,
  output logic          f1_valid,
  output logic          f2_valid,
  output logic          f3_valid,
  input  logic          f0_ready,
  input  logic          f1_ready,
  input  logic          f2_ready,
  input  logic          f3_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);
  logic [W-1:0]  d [4];
  logic [CW-1:0] c [4];
  logic [3:0]    v, r, we, ot;
  assign r  = {f3_ready, f2_ready, f1_ready, f0_ready};
  assign ot = v & r;
  // a full register may still accept when it is draining in the same cycle
  assign i_ready = rst_n & (~v[s] | r[s]);
  assign we = (i_valid && i_ready) ? 4'b0001 << s : 4'b0000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < 4; k++) begin
        d[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      v <= we | (v & ~r);
      for (int k = 0; k < 4; k++) begin
        if (we[k]) d[k] <= i;
        if (ot[k]) c[k] <= c[k] + CW'(1);
      end
    end
  end
  assign f0 = d[0];
  assign f1 = d[1];
  assign f2 = d[2];
  assign f3 = d[3];
  assign {f3_valid, f2_valid, f1_valid, f0_valid} = v;
  assign cnt0 = c[0];
  assign cnt1 = c[1];
  assign cnt2 = c[2];
  assign cnt3 = c[3];
endmodule
